// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the UART transmit FIFO: default geometry, the
// launch timeout and the launch FSM state encoding.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

   // Default FIFO depth is 2**DEPTH_BITS_DEF bytes
   localparam int DEPTH_BITS_DEF    = 4;
   // Default number of cycles to wait for tx_active after a launch
   localparam int START_TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_START = 2'd1,
      ST_WAIT_DONE  = 2'd2
   } tx_state_e;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_mem
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are not reset; validity is tracked by
// the pointers and level in the parent.
//
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
// ---------------------------------------------------------------------------
module uart_tx_fifo_mem #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_BITS-1:0] rdata
);

   logic [DATA_BITS-1:0] mem_r [0:(2**ADDR_BITS)-1];

   // Storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule : uart_tx_fifo_mem

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO between a core and a UART transmitter. The core writes bytes
// with wr_en/wr_data; a small FSM launches one byte at a time into the UART
// with a one-cycle start_TX pulse and waits for the UART to go busy and
// then idle again before launching the next byte.
//
// Ports:
//   clk          - clock, all state on rising edge
//   reset_n      - asynchronous active-low reset
//   sync_reset   - synchronous active-high clear
//   wr_en        - byte write strobe from core
//   wr_data      - byte from core
//   full         - FIFO holds 2**DEPTH_BITS bytes
//   empty        - FIFO holds no bytes
//   level        - number of bytes stored
//   overflow     - sticky: a write was dropped because the FIFO was full
//   clr_overflow - clears overflow (a simultaneous drop keeps it set)
//   start_TX     - one-cycle launch pulse to the UART
//   tx_data      - byte presented to the UART, held until the next launch
//   tx_active    - UART busy
//   busy         - bytes pending or a transmission in progress
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH_BITS    = DEPTH_BITS_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sync_reset,
   input  logic                wr_en,
   input  logic [7:0]          wr_data,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_BITS:0] level,
   output logic                overflow,
   input  logic                clr_overflow,
   output logic                start_TX,
   output logic [7:0]          tx_data,
   input  logic                tx_active,
   output logic                busy
);

   localparam int CNT_BITS = $clog2(START_TIMEOUT + 1);

   localparam logic [DEPTH_BITS:0]   LEVEL_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
   localparam logic [DEPTH_BITS:0]   LEVEL_ZERO = {(DEPTH_BITS+1){1'b0}};
   localparam logic [DEPTH_BITS:0]   LEVEL_ONE  = (DEPTH_BITS+1)'(1'b1);
   localparam logic [DEPTH_BITS-1:0] PTR_ZERO   = {DEPTH_BITS{1'b0}};
   localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1'b1);
   localparam logic [CNT_BITS-1:0]   CNT_ZERO   = {CNT_BITS{1'b0}};
   localparam logic [CNT_BITS-1:0]   CNT_ONE    = CNT_BITS'(1'b1);
   localparam logic [CNT_BITS-1:0]   CNT_LAST   = CNT_BITS'(START_TIMEOUT - 1);

   logic [DEPTH_BITS-1:0] wr_ptr_r;
   logic [DEPTH_BITS-1:0] rd_ptr_r;
   logic [DEPTH_BITS:0]   level_r;
   logic                  overflow_r;
   logic                  avail_r;
   tx_state_e             state_r;
   logic [CNT_BITS-1:0]   wait_cnt_r;
   logic                  start_tx_r;
   logic [7:0]            tx_data_r;

   logic                  full_s;
   logic                  empty_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  drop_s;
   logic [7:0]            head_s;

   uart_tx_fifo_mem #(
      .ADDR_BITS (DEPTH_BITS),
      .DATA_BITS (8)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (wr_data),
      .raddr (rd_ptr_r),
      .rdata (head_s)
   );

   // FIFO status decode and this cycle's push/pop/drop decisions
   always_comb begin
      full_s  = 1'b0;
      empty_s = 1'b0;
      pop_s   = 1'b0;
      push_s  = 1'b0;
      drop_s  = 1'b0;
      full_s  = (level_r == LEVEL_FULL);
      empty_s = (level_r == LEVEL_ZERO);
      // avail_r gives a fresh byte one settling cycle before it may launch
      if ((state_r == ST_IDLE) && avail_r && !empty_s && !tx_active) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      // a pop in the same cycle frees the slot a full FIFO needs
      if (wr_en && (!full_s || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      if (wr_en && full_s && !pop_s) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end

   // FIFO pointers, level and sticky overflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LEVEL_ZERO;
         overflow_r <= 1'b0;
      end else if (sync_reset) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LEVEL_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LEVEL_ONE;
            2'b01:   level_r <= level_r - LEVEL_ONE;
            default: level_r <= level_r;
         endcase
         // set wins over clear
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_overflow) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   // Delayed non-empty qualifier for the launch decision
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avail_r <= 1'b0;
      end else if (sync_reset) begin
         avail_r <= 1'b0;
      end else begin
         avail_r <= !empty_s;
      end
   end

   // Launch FSM with registered start_TX / tx_data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= CNT_ZERO;
         start_tx_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else if (sync_reset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= CNT_ZERO;
         start_tx_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         start_tx_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  tx_data_r  <= head_s;
                  start_tx_r <= 1'b1;
                  wait_cnt_r <= CNT_ZERO;
                  state_r    <= ST_WAIT_START;
               end
            end
            ST_WAIT_START: begin
               // a UART that never answers still releases the FSM;
               // the byte is treated as sent
               if (tx_active) begin
                  state_r <= ST_WAIT_DONE;
               end else if (wait_cnt_r == CNT_LAST) begin
                  state_r <= ST_IDLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_ONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_active) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign full     = full_s;
   assign empty    = empty_s;
   assign level    = level_r;
   assign overflow = overflow_r;
   assign start_TX = start_tx_r;
   assign tx_data  = tx_data_r;
   assign busy     = !empty_s || (state_r != ST_IDLE);

endmodule : uart_tx_fifo
